// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Start/busy/done handshake; bcd/ovf hold the last result until the next DONE.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3,
    parameter int CNT_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [BIN_W-1:0]     sh_q, sh_d;
    logic [BCD_W-1:0]     wk_q, wk_d;
    logic                 co_q, co_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;

    logic [BCD_W-1:0]     wk_adj;
    logic [BCD_W-1:0]     wk_shift;
    logic                 co_next;

    // Per-digit correction: digits >= 5 get +3 so the following shift carries at 10.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] w);
        logic [BCD_W-1:0] r;
        logic [3:0]       d;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = w[4*i +: 4];
            if (d >= 4'd5) begin
                d = d + 4'd3;
            end
            r[4*i +: 4] = d;
        end
        return r;
    endfunction

    always_comb begin
        wk_adj   = add3_digits(wk_q);
        wk_shift = {wk_adj[BCD_W-2:0], sh_q[BIN_W-1]};
        co_next  = co_q | wk_adj[BCD_W-1];

        state_d = state_q;
        sh_d    = sh_q;
        wk_d    = wk_q;
        co_d    = co_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    sh_d    = bin;
                    wk_d    = '0;
                    co_d    = 1'b0;
                    cnt_d   = CNT_W'(BIN_W);
                    busy_d  = 1'b1;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                wk_d  = wk_shift;
                sh_d  = sh_q << 1;
                co_d  = co_next;
                cnt_d = cnt_q - CNT_W'(1);
                // Result is loaded on entry to DONE so it is visible during the done pulse.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    bcd_d   = wk_shift;
                    ovf_d   = co_next;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            wk_q    <= '0;
            co_q    <= 1'b0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            wk_q    <= wk_d;
            co_q    <= co_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bcd  = bcd_q;
    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a 3-digit and a 2-digit instance, checked against
// a decimal reference computed with plain arithmetic.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst;
    logic        start_r;
    logic [7:0]  bin_r;
    logic        sel;

    logic        start_a, start_b;
    logic [11:0] bcd_a;
    logic [7:0]  bcd_b;
    logic        busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;

    logic [11:0] cur_bcd;
    logic        cur_busy, cur_done, cur_ovf;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_done_cyc = 0;
    int dig_viol = 0;
    int stab_viol = 0;
    logic mon_en = 1'b0;
    logic rst_edge = 1'b1;
    logic [11:0] prev_a = '0;
    logic [7:0]  prev_b = '0;

    assign start_a  = start_r & ~sel;
    assign start_b  = start_r & sel;
    assign cur_bcd  = sel ? {4'h0, bcd_b} : bcd_a;
    assign cur_busy = sel ? busy_b : busy_a;
    assign cur_done = sel ? done_b : done_a;
    assign cur_ovf  = sel ? ovf_b : ovf_a;

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3), .CNT_W(5)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bin(bin_r),
        .bcd(bcd_a), .busy(busy_a), .done(done_a), .ovf(ovf_a)
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2), .CNT_W(5)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bin(bin_r),
        .bcd(bcd_b), .busy(busy_b), .done(done_b), .ovf(ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= rst;
    end

    function automatic int bad_digits(input logic [11:0] b, input int n);
        int k;
        k = 0;
        for (int i = 0; i < n; i++) begin
            if (b[4*i +: 4] > 4'd9) k++;
        end
        return k;
    endfunction

    // Digits must always be decimal; results may only move on done or after reset.
    always @(negedge clk) begin
        dig_viol <= dig_viol + bad_digits(bcd_a, 3) + bad_digits({4'h0, bcd_b}, 2);
        if (mon_en && !rst_edge &&
            ((bcd_a !== prev_a && !done_a) || (bcd_b !== prev_b && !done_b))) begin
            stab_viol <= stab_viol + 1;
        end
        prev_a <= bcd_a;
        prev_b <= bcd_b;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v, input int digits);
        logic [11:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int pow10(input int digits);
        int p;
        p = 1;
        for (int i = 0; i < digits; i++) p = p * 10;
        return p;
    endfunction

    task automatic run_conv(input int v, input string tag);
        int c;
        int busy_n;
        int nd;
        logic [11:0] hold;
        bit stable;
        nd = sel ? 2 : 3;
        @(negedge clk);
        hold    = cur_bcd;
        start_r = 1'b1;
        bin_r   = v[7:0];
        @(negedge clk);
        start_r = 1'b0;
        bin_r   = 8'($urandom);
        c = 0;
        busy_n = 0;
        stable = 1'b1;
        while (!cur_done && c < 40) begin
            if (cur_busy) busy_n++;
            if (cur_bcd !== hold) stable = 1'b0;
            @(negedge clk);
            c++;
        end
        if (cur_busy) busy_n++;
        last_done_cyc = cyc;
        chk({tag, "_lat"}, c, 8);
        chk({tag, "_busy_len"}, busy_n, 9);
        chk({tag, "_hold"}, 32'(stable), 1);
        chk({tag, "_bcd"}, cur_bcd, ref_bcd(v, nd));
        chk({tag, "_ovf"}, cur_ovf, (v > pow10(nd) - 1) ? 1 : 0);
    endtask

    initial begin
        int t0, t1, t2, c, dn;
        rst = 1'b1;
        start_r = 1'b0;
        bin_r = '0;
        sel = 1'b0;
        repeat (2) @(negedge clk);
        // Reset must win over a simultaneous start.
        start_r = 1'b1;
        bin_r = 8'd77;
        @(negedge clk);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_bcd_a", bcd_a, 0);
        chk("rst_ovf_a", ovf_a, 0);
        chk("rst_bcd_b", bcd_b, 0);
        chk("rst_busy_b", busy_b, 0);
        rst = 1'b0;
        start_r = 1'b0;
        @(negedge clk);
        chk("rst_start_ignored", busy_a, 0);
        mon_en = 1'b1;

        run_conv(255, "t1_255");

        run_conv(0, "t2_0");
        t0 = last_done_cyc;
        run_conv(99, "t2_99");
        t1 = last_done_cyc;
        run_conv(128, "t2_128");
        t2 = last_done_cyc;
        chk("t2_gap1", t1 - t0, 10);
        chk("t2_gap2", t2 - t1, 10);

        sel = 1'b1;
        run_conv(200, "t3_200");
        run_conv(99, "t3_99");
        sel = 1'b0;

        // Start requests during CONV and during DONE must be dropped.
        @(negedge clk);
        start_r = 1'b1;
        bin_r = 8'd37;
        @(negedge clk);
        start_r = 1'b0;
        c = 0;
        dn = 0;
        for (int i = 0; i < 25; i++) begin
            if (c == 3 || done_a) begin
                start_r = 1'b1;
                bin_r = 8'd200;
            end else begin
                start_r = 1'b0;
            end
            if (done_a) dn++;
            @(negedge clk);
            c++;
        end
        start_r = 1'b0;
        chk("t4_done_count", dn, 1);
        chk("t4_bcd", bcd_a, 12'h037);
        chk("t4_idle", busy_a, 0);

        // Reset in the middle of a conversion.
        @(negedge clk);
        start_r = 1'b1;
        bin_r = 8'd200;
        @(negedge clk);
        start_r = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_busy", busy_a, 0);
        chk("t5_done", done_a, 0);
        chk("t5_bcd", bcd_a, 0);
        chk("t5_ovf", ovf_a, 0);
        run_conv(45, "t5_45");

        for (int v = 0; v < 256; v++) begin
            run_conv(v, "sweep");
        end

        for (int i = 0; i < 40; i++) begin
            sel = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_conv(int'($urandom_range(0, 255)), sel ? "rand_b" : "rand_a");
        end
        sel = 1'b0;

        @(negedge clk);
        chk("digit_range", dig_viol, 0);
        chk("result_stable", stab_viol, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
